// File: rtl/cov_bram_reader.sv
// cov_bram_reader: fetches the covariance matrix from BRAM port B in row-major order
// once the writer signals completion, and streams it out over valid/ready.
// Optional macro UPPER_TRI_EN: fetch only the upper triangle (col >= row).
`timescale 1ns/1ps
module cov_bram_reader #(
  parameter int unsigned MATRIX_SIZE  = 4,
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned BRAM_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           enb,
  output logic [ADDR_WIDTH-1:0]          addrb,
  input  logic [31:0]                    doutb,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_SIZE-1:0]           out_data,
  output logic [$clog2(MATRIX_SIZE)-1:0] out_row,
  output logic [$clog2(MATRIX_SIZE)-1:0] out_col,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned IdxW      = $clog2(MATRIX_SIZE);
  localparam int unsigned FifoDepth = BRAM_LATENCY + 2;
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);
  localparam logic [IdxW-1:0] MaxIdx = IdxW'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         row_q, row_d, col_q, col_d;
  logic                    last_issue;
  logic                    credit_ok;
  logic [CntW-1:0]         in_flight;

  // In-flight read pipe: valid bits plus the tags of each outstanding read
  logic [BRAM_LATENCY-1:0] pipe_vld_q;
  logic [BRAM_LATENCY-1:0] pipe_last_q;
  logic [IdxW-1:0]         pipe_row_q [BRAM_LATENCY];
  logic [IdxW-1:0]         pipe_col_q [BRAM_LATENCY];

  // Skid FIFO, first-word fall-through
  logic [DATA_SIZE-1:0]    fifo_data_q [FifoDepth];
  logic [IdxW-1:0]         fifo_row_q  [FifoDepth];
  logic [IdxW-1:0]         fifo_col_q  [FifoDepth];
  logic [FifoDepth-1:0]    fifo_last_q;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         fifo_count_q;
  logic                    fifo_push, fifo_pop, fifo_full;

  logic                    unused_doutb;
  assign unused_doutb = ^doutb[31:DATA_SIZE];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Credit accounting and issue address from registered state only
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      in_flight = in_flight + CntW'(pipe_vld_q[i]);
    end
    credit_ok  = (32'(in_flight) + 32'(fifo_count_q)) < FifoDepth;
    last_issue = (row_q == MaxIdx) && (col_q == MaxIdx);
    addrb      = ADDR_WIDTH'(32'(row_q) * MATRIX_SIZE + 32'(col_q));
  end

  // FSM next-state, issue enable and status outputs
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    enb     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StFetch: begin
        busy = 1'b1;
        if (credit_ok) begin
          enb = 1'b1;
          if (last_issue) begin
            // Park the counters at zero so addrb idles at 0
            state_d = StDrain;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == MaxIdx) begin
            row_d = row_q + IdxW'(1);
`ifdef UPPER_TRI_EN
            col_d = row_q + IdxW'(1);
`else
            col_d = '0;
`endif
          end else begin
            col_d = col_q + IdxW'(1);
          end
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (fifo_pop && out_last) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and issue counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Valid pipe; clearing it on reset discards reads still returning from BRAM
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= enb;
      for (int i = 1; i < BRAM_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  // Tag pipe; contents only matter where the matching valid bit is set
  always_ff @(posedge clk) begin
    pipe_row_q[0]  <= row_q;
    pipe_col_q[0]  <= col_q;
    pipe_last_q[0] <= last_issue;
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      pipe_row_q[i]  <= pipe_row_q[i-1];
      pipe_col_q[i]  <= pipe_col_q[i-1];
      pipe_last_q[i] <= pipe_last_q[i-1];
    end
  end

  assign fifo_push = pipe_vld_q[BRAM_LATENCY-1];
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_full = (fifo_count_q == CntW'(FifoDepth));

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_q[wr_ptr_q] <= doutb[DATA_SIZE-1:0];
      fifo_row_q[wr_ptr_q]  <= pipe_row_q[BRAM_LATENCY-1];
      fifo_col_q[wr_ptr_q]  <= pipe_col_q[BRAM_LATENCY-1];
      fifo_last_q[wr_ptr_q] <= pipe_last_q[BRAM_LATENCY-1];
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (fifo_push && !fifo_pop)      fifo_count_q <= fifo_count_q + CntW'(1);
      else if (!fifo_push && fifo_pop) fifo_count_q <= fifo_count_q - CntW'(1);
    end
  end

  // Head of FIFO drives the stream; fields read as zero while nothing is valid
  always_comb begin
    out_valid = (fifo_count_q != '0);
    out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    out_row   = out_valid ? fifo_row_q[rd_ptr_q]  : '0;
    out_col   = out_valid ? fifo_col_q[rd_ptr_q]  : '0;
    out_last  = out_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
  end

  // The credit rule must keep returning data from ever meeting a full FIFO
  assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule

// File: doc/cov_bram_reader.md
Name: cov_bram_reader

Overview:
- Read-side counterpart of the covariance-matrix BRAM writer.
- Waits for the writer's `done_writing` pulse, then fetches the MATRIX_SIZE x MATRIX_SIZE covariance matrix from BRAM port B in row-major order.
- Streams the elements to the Jacobi eigen-solver over a valid/ready interface.
- Absorbs BRAM read latency and downstream backpressure with a credit-limited skid FIFO, so no element is lost or duplicated.

Parameters:
- MATRIX_SIZE, 4, matrix dimension N.
- DATA_SIZE, 8, element width; taken from the low bits of the 32-bit BRAM word.
- ADDR_WIDTH, 4, BRAM address width; must satisfy 2^ADDR_WIDTH >= N*N.
- BRAM_LATENCY, 2, cycles from enb/addrb sampled to doutb valid (1 or 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; connected to the writer's done_writing.
- enb  out  1  BRAM port B enable; one read per asserted cycle.
- addrb  out  ADDR_WIDTH  BRAM port B address.
- doutb  in  32  BRAM port B read data.
- out_valid  out  1  out_data holds a valid element.
- out_ready  in  1  consumer accepts the element when out_valid is also high.
- out_data  out  DATA_SIZE  element value, doutb[DATA_SIZE-1:0].
- out_row  out  $clog2(N)  row index of out_data.
- out_col  out  $clog2(N)  column index of out_data.
- out_last  out  1  high with the final element of the matrix.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse in the cycle after the last handshake.

Behaviour:
- Reset values: enb=0, addrb=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, done=0. Reset also clears the FIFO, the in-flight pipeline, and all counters.
- States:
  - IDLE: start=1 -> FETCH; row/col issue counters set to 0.
  - FETCH: issue reads. After the last issue -> DRAIN.
  - DRAIN: no further reads. After the handshake with out_last=1 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start in any state other than IDLE is ignored.
- Issue rule:
  - enb=1 in a FETCH cycle only when (in_flight + fifo_count) < BRAM_LATENCY+2, using registered counts; a same-cycle pop gives no credit.
  - Issue address is row*N + col. col increments first; at N-1 it wraps to 0 and row increments.
- Return path:
  - A BRAM_LATENCY-deep valid shift register tracks in-flight reads. Each carries its row, col and last tags alongside.
  - Returning data is written into the FIFO (depth BRAM_LATENCY+2, first-word fall-through).
  - out_valid = FIFO not empty. Pop on out_valid & out_ready.
- Latency: start sampled in cycle 0 -> first enb in cycle 1 -> out_valid in cycle BRAM_LATENCY+2.
- Throughput: with out_ready held high, one element per cycle.
- FIFO full: guaranteed not to overflow by the credit rule. An attempted write to a full FIFO is an assertion failure.
- Simultaneous FIFO write and pop: both occur and the count is unchanged.
- doutb[31:DATA_SIZE] is ignored.
- The out_* signals stay stable while out_valid=1 and out_ready=0.
- Reset mid-operation: everything returns to reset values on the next edge. BRAM data arriving after reset is discarded, because the valid pipe has been cleared.

Optional Feature:
- UPPER_TRI_EN:
  - Defined: only elements with col >= row are fetched and streamed, N(N+1)/2 in total.
  - Each row's column counter starts at row. out_last goes with element (N-1,N-1).
  - The Jacobi unit mirrors the symmetric lower half itself.
- Undefined: all N*N elements are streamed.

Test Plan:
- BRAM addr k holds k+1, N=4, BRAM_LATENCY=2, out_ready=1:
  - start in cycle 0 -> out_valid first in cycle 4, out_data 1..16 on consecutive cycles.
  - (row,col) goes (0,0)..(3,3); out_last with 16; done pulse in the cycle after; busy low afterwards.
- Same data, out_ready low for cycles 5-10:
  - enb stops after the FIFO plus in-flight reads total 4.
  - out_data holds steady while stalled; the full sequence 1..16 is delivered exactly once, with no gaps or duplicates.
- Reset asserted after the 7th handshake:
  - All outputs return to 0 next cycle; late doutb returns produce no out_valid.
  - A new start streams again from out_data=1.
- start re-pulsed while busy -> ignored; exactly 16 elements and a single done pulse.
- BRAM addr 0 = 0xFFFFFF05 -> first out_data = 0x05.
- UPPER_TRI_EN defined:
  - addrb sequence is 0,1,2,3,5,6,7,10,11,15.
  - out_data is 1,2,3,4,6,7,8,11,12,16, with out_last on 16.
